// File: rtl/serial_adder.sv
// serial_adder: bit-serial two's-complement adder, one bit per clock LSB first.
// Define SERIAL_ADDER_SUB_EN to add a sub input that turns the operation into a-b.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c, r_cout, r_ovf;
  logic             w_s, w_cout, w_last, w_sub;
`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif
  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    busy = r_state != IDLE;
    done = r_state == DONE;
  end
  // Subtraction reuses the adder as a + ~b + 1 by presetting the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a   <= a;
      r_b   <= w_sub ? ~b : b;
      r_c   <= w_sub;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= {w_s, r_res[WIDTH-1:1]};
      r_c   <= w_cout;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= {w_s, r_res[WIDTH-1:1]};
        r_cout <= w_cout;
        r_ovf  <= r_c ^ w_cout;
      end
    end
  end
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table vectors, hand-written corner sequences and random
// operands checked against an integer reference of two's-complement addition.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       sub = 1'b0;
  logic       busy, done, carry_out, overflow;
  logic [7:0] sum;
  int         passed = 0, total = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x, y, s;
    logic       c, o;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: unsigned sum for carry, signed integer range test for overflow.
  function automatic logic [9:0] model(input logic [7:0] x, y, input logic s);
    int u, v;
    logic [7:0] r;
    u = s ? int'(x) + int'(8'(~y)) + 1 : int'(x) + int'(y);
    v = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    r = u[7:0];
    return {(v > 127 || v < -128), (u > 255), r};
  endfunction

  // Start one op and observe a fixed 12-cycle window after the start edge.
  task automatic run_op(input logic [7:0] x, y, input logic s,
                        output logic [7:0] rs, output logic rc, ro,
                        output int lat, bc, nd);
    lat = 0; bc = 0; nd = 0; rs = '0; rc = 0; ro = 0;
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y; sub = ~s;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (busy) bc++;
      if (done) begin
        nd++;
        if (lat == 0) begin lat = cyc; rs = sum; rc = carry_out; ro = overflow; end
      end
      if (cyc < 12) @(negedge clk);
    end
  endtask

  vec_t       tbl[7];
  logic [7:0] rs, prev;
  logic       rc, ro;
  logic [9:0] m;
  int         lat, bc, nd, cyc;

  initial begin
    tbl[0] = '{8'd100, 8'd27, 8'h7F, 1'b0, 1'b0};
    tbl[1] = '{8'd100, 8'd28, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'h80,  8'hFF, 8'h7F, 1'b1, 1'b1};
    tbl[3] = '{8'h7F,  8'h7F, 8'hFE, 1'b0, 1'b1};
    tbl[4] = '{8'hFF,  8'h01, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'd10,  8'd5,  8'h0F, 1'b0, 1'b0};
    tbl[6] = '{8'h00,  8'h00, 8'h00, 1'b0, 1'b0};

    #23;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", carry_out, 0);
    chk("reset_ovf", overflow, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].x, tbl[i].y, 1'b0, rs, rc, ro, lat, bc, nd);
      chk($sformatf("tbl%0d_sum", i), rs, tbl[i].s);
      chk($sformatf("tbl%0d_cout", i), rc, tbl[i].c);
      chk($sformatf("tbl%0d_ovf", i), ro, tbl[i].o);
      chk($sformatf("tbl%0d_latency", i), lat, 9);
      chk($sformatf("tbl%0d_busy_cycles", i), bc, 9);
      chk($sformatf("tbl%0d_done_count", i), nd, 1);
    end

    // Start pulsed during RUN is dropped; previous result stays visible.
    prev = sum;
    @(negedge clk); a = 8'd1; b = 8'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    chk("run_holds_prev_sum", sum, prev);
    @(negedge clk); @(negedge clk);
    a = 8'd50; b = 8'd50; start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd = 0; rs = '0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin nd++; rs = sum; end
      @(negedge clk);
    end
    chk("busy_start_done_count", nd, 1);
    chk("busy_start_sum", rs, 8'h03);

    // Start held high across DONE is taken on the first IDLE edge.
    a = 8'd3; b = 8'd4; start = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("held_first_done_seen", done, 1);
    chk("held_first_sum", sum, 8'h07);
    a = 8'd20; b = 8'd22;
    @(negedge clk);
    chk("held_idle_busy", busy, 0);
    @(negedge clk); start = 1'b0;
    chk("held_accepted_busy", busy, 1);
    cyc = 1;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("held_second_latency", cyc, 9);
    chk("held_second_sum", sum, 8'd42);

    // Asynchronous reset four cycles into RUN.
    @(negedge clk); @(negedge clk);
    a = 8'h55; b = 8'h33; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_sum", sum, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_cout", carry_out, 0);
    chk("midreset_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("midreset_no_done", nd, 0);
    run_op(8'd10, 8'd5, 1'b0, rs, rc, ro, lat, bc, nd);
    chk("after_reset_sum", rs, 8'h0F);
    chk("after_reset_latency", lat, 9);

    for (int i = 0; i < 100; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom);
      y = 8'($urandom);
      m = model(x, y, 1'b0);
      run_op(x, y, 1'b0, rs, rc, ro, lat, bc, nd);
      chk($sformatf("rnd%0d_sum(%0h+%0h)", i, x, y), rs, m[7:0]);
      chk($sformatf("rnd%0d_cout", i), rc, m[8]);
      chk($sformatf("rnd%0d_ovf", i), ro, m[9]);
      chk($sformatf("rnd%0d_latency", i), lat, 9);
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'd5, 8'd7, 1'b1, rs, rc, ro, lat, bc, nd);
    chk("sub_5_7_sum", rs, 8'hFE);
    chk("sub_5_7_cout", rc, 0);
    chk("sub_5_7_ovf", ro, 0);
    run_op(8'h80, 8'h01, 1'b1, rs, rc, ro, lat, bc, nd);
    chk("sub_80_01_sum", rs, 8'h7F);
    chk("sub_80_01_ovf", ro, 1);
    for (int i = 0; i < 30; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom);
      y = 8'($urandom);
      m = model(x, y, 1'b1);
      run_op(x, y, 1'b1, rs, rc, ro, lat, bc, nd);
      chk($sformatf("rsub%0d_sum", i), rs, m[7:0]);
      chk($sformatf("rsub%0d_cout", i), rc, m[8]);
      chk($sformatf("rsub%0d_ovf", i), ro, m[9]);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
